// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - shared constants and types for the CAVLC coefficient analyzer
package cavlc_pkg;

  localparam int DEF_COEF_W   = 16;
  localparam int DEF_MAX_COEF = 16;
  localparam int DEF_CNT_W    = $clog2(DEF_MAX_COEF + 1);

  localparam int BLK_LUMA4X4 = 16;
  localparam int BLK_AC      = 15;
  localparam int BLK_CDC420  = 4;
  localparam int BLK_CDC422  = 8;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_STATS   = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // One buffered non-zero level and the zero run that preceded it in scan order
  typedef struct packed {
    logic signed [DEF_COEF_W-1:0] level;
    logic [DEF_CNT_W-1:0]         run;
  } nz_entry_t;

endpackage

// File: rtl/cavlc_nz_buffer.sv
// rtl/cavlc_nz_buffer.sv - append-only register file of non-zero levels with one random read port
module cavlc_nz_buffer #(
  parameter int COEF_W   = 16,
  parameter int MAX_COEF = 16,
  parameter int CNT_W    = $clog2(MAX_COEF + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [COEF_W-1:0] wr_level,
  input  logic [CNT_W-1:0]  wr_run,
  output logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [COEF_W-1:0] rd_level,
  output logic [CNT_W-1:0]  rd_run
);

  logic [COEF_W-1:0] level_q [MAX_COEF];
  logic [CNT_W-1:0]  run_q   [MAX_COEF];
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < MAX_COEF; i++) begin
        level_q[i] <= '0;
        run_q[i]   <= '0;
      end
    end else if (clr) begin
      count_q <= '0;
    end else if (wr_en && (count_q < CNT_W'(MAX_COEF))) begin
      count_q <= count_q + CNT_W'(1);
      for (int i = 0; i < MAX_COEF; i++) begin
        if (count_q == CNT_W'(i)) begin
          level_q[i] <= wr_level;
          run_q[i]   <= wr_run;
        end
      end
    end
  end

  // Explicit compare mux keeps the index width independent of the depth
  always_comb begin
    rd_level = '0;
    rd_run   = '0;
    for (int i = 0; i < MAX_COEF; i++) begin
      if (rd_idx == CNT_W'(i)) begin
        rd_level = level_q[i];
        rd_run   = run_q[i];
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cavlc_coeff_analyzer.sv
// rtl/cavlc_coeff_analyzer.sv - CAVLC statistics and reverse-order level replay for one coefficient block
module cavlc_coeff_analyzer
  import cavlc_pkg::*;
#(
  parameter int COEF_W   = DEF_COEF_W,
  parameter int MAX_COEF = DEF_MAX_COEF,
  parameter int CNT_W    = $clog2(MAX_COEF + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CNT_W-1:0]         blk_len_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     in_last,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic [CNT_W-1:0]         st_total_coeff,
  output logic [1:0]               st_trailing_ones,
  output logic [2:0]               st_t1_signs,
  output logic [CNT_W-1:0]         st_total_zeros,
  output logic                     lv_valid,
  input  logic                     lv_ready,
  output logic signed [COEF_W-1:0] lv_level,
  output logic [CNT_W-1:0]         lv_run_before,
  output logic [CNT_W-1:0]         lv_zeros_left,
  output logic                     lv_is_t1,
  output logic                     lv_last,
  output logic                     len_err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  idx_q, blk_len_q, zrun_q, last_nz_q, k_q, zl_q;
  logic [1:0]        t1run_q;
  logic [2:0]        t1sig_q;
  logic              len_err_q;

  logic [CNT_W-1:0]  tc, rd_run, len_eff, total_zeros, t1_ext;
  logic [COEF_W-1:0] rd_level;
  logic              hs, is_zero, is_one, at_limit, end_blk;
  logic              emit_hs, at_k0, start_emit, clr_all;

  assign in_ready = (state_q == ST_COLLECT);
  assign st_valid = (state_q == ST_STATS);
  assign lv_valid = (state_q == ST_EMIT);

  assign hs      = in_valid & in_ready;
  assign is_zero = (in_coef == '0);
  assign is_one  = (in_coef == COEF_W'(1)) || (in_coef == '1);

  // Block length is latched with the first coefficient, so use the live input until then
  assign len_eff  = (idx_q == '0) ? blk_len_i : blk_len_q;
  assign at_limit = (idx_q == len_eff - ONE) || (idx_q == CNT_W'(MAX_COEF - 1));
  assign end_blk  = hs & (in_last | at_limit);

  assign total_zeros = (tc != '0) ? (last_nz_q + ONE - tc) : '0;
  assign t1_ext      = {{(CNT_W-2){1'b0}}, t1run_q};

  assign emit_hs    = lv_valid & lv_ready;
  assign at_k0      = (k_q == '0);
  assign start_emit = st_valid & st_ready & (tc != '0);
  assign clr_all    = (st_valid & st_ready & (tc == '0)) | (emit_hs & at_k0);

  cavlc_nz_buffer #(
    .COEF_W   (COEF_W),
    .MAX_COEF (MAX_COEF),
    .CNT_W    (CNT_W)
  ) u_nz_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_all),
    .wr_en    (hs & ~is_zero),
    .wr_level (in_coef),
    .wr_run   (zrun_q),
    .count    (tc),
    .rd_idx   (k_q),
    .rd_level (rd_level),
    .rd_run   (rd_run)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (end_blk) state_d = ST_STATS;
      ST_STATS:   if (st_ready) state_d = (tc != '0) ? ST_EMIT : ST_COLLECT;
      ST_EMIT:    if (emit_hs && at_k0) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      idx_q     <= '0;
      blk_len_q <= '0;
      zrun_q    <= '0;
      last_nz_q <= '0;
      t1run_q   <= '0;
      t1sig_q   <= '0;
      k_q       <= '0;
      zl_q      <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_err_q <= hs & ~in_last & at_limit;
      if (clr_all) begin
        idx_q     <= '0;
        blk_len_q <= '0;
        zrun_q    <= '0;
        last_nz_q <= '0;
        t1run_q   <= '0;
        t1sig_q   <= '0;
        k_q       <= '0;
        zl_q      <= '0;
      end else begin
        if (hs) begin
          idx_q <= idx_q + ONE;
          if (idx_q == '0) blk_len_q <= blk_len_i;
          if (is_zero) begin
            zrun_q <= zrun_q + ONE;
          end else begin
            zrun_q    <= '0;
            last_nz_q <= idx_q;
            // Newest sign enters bit 0, which is the first trailing one emitted
            if (is_one) begin
              t1run_q <= (t1run_q == 2'd3) ? 2'd3 : t1run_q + 2'd1;
              t1sig_q <= {t1sig_q[1:0], in_coef[COEF_W-1]};
            end else begin
              t1run_q <= '0;
              t1sig_q <= '0;
            end
          end
        end
        if (start_emit) begin
          k_q  <= tc - ONE;
          zl_q <= total_zeros;
        end
        if (emit_hs) begin
          k_q  <= k_q - ONE;
          zl_q <= zl_q - rd_run;
        end
      end
    end
  end

  assign st_total_coeff   = st_valid ? tc : '0;
  assign st_trailing_ones = st_valid ? t1run_q : '0;
  assign st_t1_signs      = st_valid ? t1sig_q : '0;
  assign st_total_zeros   = st_valid ? total_zeros : '0;

  assign lv_level      = lv_valid ? rd_level : '0;
  assign lv_run_before = lv_valid ? rd_run : '0;
  assign lv_zeros_left = lv_valid ? zl_q : '0;
  assign lv_is_t1      = lv_valid & (k_q >= (tc - t1_ext));
  assign lv_last       = lv_valid & at_k0;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_cavlc_coeff_analyzer.sv
// tb/tb_cavlc_coeff_analyzer.sv - directed self-checking bench for cavlc_coeff_analyzer
module tb_cavlc_coeff_analyzer;

  localparam int COEF_W   = 16;
  localparam int MAX_COEF = 16;
  localparam int CNT_W    = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [CNT_W-1:0]         blk_len_i;
  logic                     in_valid, in_ready, in_last;
  logic signed [COEF_W-1:0] in_coef;
  logic                     st_valid, st_ready;
  logic [CNT_W-1:0]         st_total_coeff, st_total_zeros;
  logic [1:0]               st_trailing_ones;
  logic [2:0]               st_t1_signs;
  logic                     lv_valid, lv_ready, lv_is_t1, lv_last, len_err;
  logic signed [COEF_W-1:0] lv_level;
  logic [CNT_W-1:0]         lv_run_before, lv_zeros_left;

  int checks = 0;
  int passes = 0;
  int len_err_cnt = 0;
  int vec [16];

  // Expected level stream for the reference mixed block, in emission order
  int mx_lvl [5] = '{1, 1, -1, -1, 3};
  int mx_run [5] = '{1, 0, 2, 0, 1};
  int mx_zl  [5] = '{4, 3, 3, 1, 1};
  int mx_t1  [5] = '{1, 1, 1, 0, 0};

  cavlc_coeff_analyzer #(
    .COEF_W   (COEF_W),
    .MAX_COEF (MAX_COEF),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .blk_len_i        (blk_len_i),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_coef          (in_coef),
    .in_last          (in_last),
    .st_valid         (st_valid),
    .st_ready         (st_ready),
    .st_total_coeff   (st_total_coeff),
    .st_trailing_ones (st_trailing_ones),
    .st_t1_signs      (st_t1_signs),
    .st_total_zeros   (st_total_zeros),
    .lv_valid         (lv_valid),
    .lv_ready         (lv_ready),
    .lv_level         (lv_level),
    .lv_run_before    (lv_run_before),
    .lv_zeros_left    (lv_zeros_left),
    .lv_is_t1         (lv_is_t1),
    .lv_last          (lv_last),
    .len_err          (len_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (len_err === 1'b1) len_err_cnt <= len_err_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic send_block(input int n, input int len, input bit use_last, input bit gaps);
    int budget;
    blk_len_i = CNT_W'(len);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_coef  = COEF_W'(vec[i]);
      in_last  = use_last && (i == n - 1);
      budget = 0;
      while (!in_ready && budget < 50) begin
        @(posedge clk); #1;
        budget++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_st(output bit ok);
    int budget = 0;
    while (st_valid !== 1'b1 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    ok = (st_valid === 1'b1);
  endtask

  task automatic wait_lv(output bit ok);
    int budget = 0;
    while (lv_valid !== 1'b1 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    ok = (lv_valid === 1'b1);
  endtask

  task automatic accept_st();
    st_ready = 1'b1;
    @(posedge clk); #1;
    st_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, st_valid, lv_valid, len_err} !== 4'b1000)
      $display("FAIL reset_ctrl got in_ready/st_valid/lv_valid/len_err=%b want 1000",
               {in_ready, st_valid, lv_valid, len_err});
    else passes++;
    checks++;
    if (st_total_coeff !== '0 || st_total_zeros !== '0 || lv_level !== '0 || lv_zeros_left !== '0)
      $display("FAIL reset_data got tc=%0d tz=%0d lvl=%0d zl=%0d want all 0",
               st_total_coeff, st_total_zeros, lv_level, lv_zeros_left);
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mixed(input bit stall);
    bit ok;
    int e0;
    vec = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    e0 = len_err_cnt;
    send_block(16, 16, 1'b1, stall);
    checks++;
    if (st_valid !== 1'b1) $display("FAIL mixed_latency st_valid=%b want 1", st_valid);
    else passes++;
    checks++;
    if ({st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros} !== {5'd5, 2'd3, 3'b100, 5'd4})
      $display("FAIL mixed_stats got tc=%0d t1=%0d signs=%b tz=%0d want tc=5 t1=3 signs=100 tz=4",
               st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros);
    else passes++;
    if (stall) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
        checks++;
        if (st_valid !== 1'b1 || st_total_coeff !== 5'd5 || st_total_zeros !== 5'd4 || st_t1_signs !== 3'b100)
          $display("FAIL stall_stats got valid=%b tc=%0d tz=%0d signs=%b want 1 5 4 100",
                   st_valid, st_total_coeff, st_total_zeros, st_t1_signs);
        else passes++;
      end
    end
    accept_st();
    for (int i = 0; i < 5; i++) begin
      if (stall) begin
        lv_ready = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          checks++;
          if (lv_valid !== 1'b1 || lv_level !== COEF_W'(mx_lvl[i]) || lv_zeros_left !== CNT_W'(mx_zl[i]))
            $display("FAIL stall_lv%0d got valid=%b lvl=%0d zl=%0d want 1 %0d %0d",
                     i, lv_valid, lv_level, lv_zeros_left, mx_lvl[i], mx_zl[i]);
          else passes++;
        end
      end
      wait_lv(ok);
      checks++;
      if ({lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last} !==
          {COEF_W'(mx_lvl[i]), CNT_W'(mx_run[i]), CNT_W'(mx_zl[i]), mx_t1[i] == 1, i == 4})
        $display("FAIL mixed_lv%0d got ok=%b lvl=%0d run=%0d zl=%0d t1=%b last=%b want lvl=%0d run=%0d zl=%0d t1=%0d last=%0d",
                 i, ok, lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last,
                 mx_lvl[i], mx_run[i], mx_zl[i], mx_t1[i], i == 4);
      else passes++;
      lv_ready = 1'b1;
      @(posedge clk); #1;
    end
    lv_ready = 1'b0;
    checks++;
    if (lv_valid !== 1'b0 || in_ready !== 1'b1 || len_err_cnt - e0 !== 0)
      $display("FAIL mixed_done got lv_valid=%b in_ready=%b len_err=%0d want 0 1 0",
               lv_valid, in_ready, len_err_cnt - e0);
    else passes++;
  endtask

  task automatic test_all_zero();
    bit ok;
    bit seen = 1'b0;
    vec = '{default: 0};
    send_block(16, 16, 1'b1, 1'b0);
    wait_st(ok);
    checks++;
    if (!ok || {st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros} !== '0)
      $display("FAIL zero_stats got ok=%b tc=%0d t1=%0d signs=%b tz=%0d want all 0",
               ok, st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros);
    else passes++;
    accept_st();
    repeat (4) begin
      if (lv_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || in_ready !== 1'b1)
      $display("FAIL zero_no_emit got lv_seen=%b in_ready=%b want 0 1", seen, in_ready);
    else passes++;
  endtask

  task automatic test_chroma_dc();
    bit ok;
    vec = '{default: 0};
    vec[0:3] = '{1, 1, 1, 1};
    send_block(4, 4, 1'b1, 1'b0);
    wait_st(ok);
    checks++;
    if (!ok || {st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros} !== {5'd4, 2'd3, 3'b000, 5'd0})
      $display("FAIL cdc_stats got tc=%0d t1=%0d signs=%b tz=%0d want tc=4 t1=3 signs=000 tz=0",
               st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros);
    else passes++;
    accept_st();
    lv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_lv(ok);
      checks++;
      if ({lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last} !==
          {COEF_W'(1), CNT_W'(0), CNT_W'(0), i < 3, i == 3})
        $display("FAIL cdc_lv%0d got lvl=%0d run=%0d zl=%0d t1=%b last=%b want 1 0 0 %0d %0d",
                 i, lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last, i < 3, i == 3);
      else passes++;
      @(posedge clk); #1;
    end
    lv_ready = 1'b0;
  endtask

  task automatic test_len_err();
    bit ok;
    int e0;
    int exp_lvl [2] = '{-1, 2};
    int exp_run [2] = '{1, 2};
    int exp_zl  [2] = '{3, 2};
    vec = '{default: 0};
    vec[2] = 2;
    vec[4] = -1;
    e0 = len_err_cnt;
    send_block(15, 15, 1'b0, 1'b0);
    wait_st(ok);
    checks++;
    if (!ok || {st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros} !== {5'd2, 2'd1, 3'b001, 5'd3})
      $display("FAIL lenerr_stats got tc=%0d t1=%0d signs=%b tz=%0d want tc=2 t1=1 signs=001 tz=3",
               st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros);
    else passes++;
    accept_st();
    lv_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_lv(ok);
      checks++;
      if ({lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last} !==
          {COEF_W'(exp_lvl[i]), CNT_W'(exp_run[i]), CNT_W'(exp_zl[i]), i == 0, i == 1})
        $display("FAIL lenerr_lv%0d got lvl=%0d run=%0d zl=%0d t1=%b last=%b want %0d %0d %0d %0d %0d",
                 i, lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last,
                 exp_lvl[i], exp_run[i], exp_zl[i], i == 0, i == 1);
      else passes++;
      @(posedge clk); #1;
    end
    lv_ready = 1'b0;
    checks++;
    if (len_err_cnt - e0 !== 1)
      $display("FAIL lenerr_pulse got %0d pulse cycles want 1", len_err_cnt - e0);
    else passes++;
  endtask

  task automatic test_reset_emit();
    bit ok;
    int e0;
    int exp_lvl [2] = '{1, -1};
    int exp_run [2] = '{0, 1};
    vec = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    send_block(16, 16, 1'b1, 1'b0);
    wait_st(ok);
    accept_st();
    lv_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lv_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lv_valid !== 1'b0 || st_valid !== 1'b0 || lv_level !== '0 || lv_zeros_left !== '0 || in_ready !== 1'b1)
      $display("FAIL rstemit_clear got lv_valid=%b st_valid=%b lvl=%0d zl=%0d in_ready=%b want 0 0 0 0 1",
               lv_valid, st_valid, lv_level, lv_zeros_left, in_ready);
    else passes++;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Short block closed early by in_last while blk_len_i still says 16
    vec = '{default: 0};
    vec[1] = -1;
    vec[2] = 1;
    e0 = len_err_cnt;
    send_block(3, 16, 1'b1, 1'b0);
    wait_st(ok);
    checks++;
    if (!ok || {st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros} !== {5'd2, 2'd2, 3'b010, 5'd1})
      $display("FAIL early_stats got tc=%0d t1=%0d signs=%b tz=%0d want tc=2 t1=2 signs=010 tz=1",
               st_total_coeff, st_trailing_ones, st_t1_signs, st_total_zeros);
    else passes++;
    accept_st();
    lv_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_lv(ok);
      checks++;
      if ({lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last} !==
          {COEF_W'(exp_lvl[i]), CNT_W'(exp_run[i]), CNT_W'(1), 1'b1, i == 1})
        $display("FAIL early_lv%0d got lvl=%0d run=%0d zl=%0d t1=%b last=%b want %0d %0d 1 1 %0d",
                 i, lv_level, lv_run_before, lv_zeros_left, lv_is_t1, lv_last,
                 exp_lvl[i], exp_run[i], i == 1);
      else passes++;
      @(posedge clk); #1;
    end
    lv_ready = 1'b0;
    checks++;
    if (len_err_cnt - e0 !== 0 || in_ready !== 1'b1)
      $display("FAIL early_done got len_err=%0d in_ready=%b want 0 1", len_err_cnt - e0, in_ready);
    else passes++;
  endtask

  initial begin
    rst_n     = 1'b0;
    blk_len_i = '0;
    in_valid  = 1'b0;
    in_coef   = '0;
    in_last   = 1'b0;
    st_ready  = 1'b0;
    lv_ready  = 1'b0;
    test_reset();
    test_mixed(1'b0);
    test_all_zero();
    test_chroma_dc();
    test_len_err();
    test_mixed(1'b1);
    test_reset_emit();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
